spi_sub_gen: RTL and testbench

SPI_SUB_GEN -- requirements
Module: spi_sub_gen

---
 rtl/spi_sub_pkg.sv | 31 +++
 rtl/spi_sub_gen_if.sv | 22 ++
 rtl/spi_shift_reg.sv | 27 ++
 rtl/spi_sub_gen.sv | 136 +++++++++++++
 tb/tb_spi_sub_gen.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_sub_pkg.sv
// Shared types for the SPI subordinate memory bridge.
// op_t    : 2-bit opcode carried in the top bits of every frame.
// state_t : frame sequencer states.
// Helpers split the opcode into its write / auto-increment flavours.
package spi_sub_pkg;

  typedef enum logic [1:0] {
    OP_READ       = 2'b00,
    OP_WRITE      = 2'b01,
    OP_READ_NEXT  = 2'b10,
    OP_WRITE_NEXT = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    EXEC,
    CAP,
    TX,
    HOLD
  } state_t;

  function automatic logic op_is_write(op_t op);
    return (op == OP_WRITE) || (op == OP_WRITE_NEXT);
  endfunction

  function automatic logic op_is_next(op_t op);
    return (op == OP_READ_NEXT) || (op == OP_WRITE_NEXT);
  endfunction

endpackage

// File: rtl/spi_sub_gen_if.sv
// Pin bundle of the SPI subordinate: serial side (cs_n, mosi, miso) and
// memory side (r_en, w_en, addr, data_o, data_i).
// slave  : the bridge itself.
// master : the SPI host plus the memory it talks to.
interface spi_sub_gen_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              r_en;
  logic              w_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_o;
  logic [DATA_W-1:0] data_i;

  modport slave  (input  cs_n, mosi, data_i,
                  output miso, r_en, w_en, addr, data_o);
  modport master (output cs_n, mosi, data_i,
                  input  miso, r_en, w_en, addr, data_o);
endinterface

// File: rtl/spi_shift_reg.sv
// Generic MSB-first shift register.
// clk/rst : clock, synchronous active-high clear.
// load    : parallel load of din (wins over shift).
// shift   : shift left one place, sin enters at bit 0.
// q/sout  : parallel contents / serial out (MSB).
module spi_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             sin,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             sout
);

  always_ff @(posedge clk) begin
    if (rst)        q <= '0;
    else if (load)  q <= din;
    else if (shift) q <= {q[WIDTH-2:0], sin};
  end

  assign sout = q[WIDTH-1];

endmodule

// File: rtl/spi_sub_gen.sv
// SPI subordinate that turns one frame {op, addr, data} per cs_n assertion
// into a single memory read or write strobe and echoes {op, eff addr, data}.
// sclk : sole clock (posedge).   rst : synchronous active-high reset.
// bus  : cs_n/mosi/miso serial pins and r_en/w_en/addr/data_o/data_i memory port.
module spi_sub_gen
  import spi_sub_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic         sclk,
  input  logic         rst,
  spi_sub_gen_if.slave bus
);

  localparam int FRAME_W = 2 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [ADDR_W-1:0]   ptr, addr_q, eff;
  logic [DATA_W-1:0]   data_q, d_cap;
  logic                r_en_q, w_en_q, miso_q, miso_n;
  logic                rx_shift, tx_load, tx_shift, exec;
  logic [FRAME_W-1:0]  rx_q, tx_q, frame_out;
  logic                rx_sout, tx_sout;
  op_t                 op;
  logic                unused;

  spi_shift_reg #(.WIDTH(FRAME_W)) u_rx (
    .clk(sclk), .rst(rst), .load(1'b0), .shift(rx_shift), .sin(bus.mosi),
    .din('0), .q(rx_q), .sout(rx_sout)
  );

  // The response MSB goes straight to miso at load time, so tx holds the
  // remaining bits pre-shifted; its MSB is always the next bit to send.
  spi_shift_reg #(.WIDTH(FRAME_W)) u_tx (
    .clk(sclk), .rst(rst), .load(tx_load), .shift(tx_shift), .sin(1'b0),
    .din({frame_out[FRAME_W-2:0], 1'b0}), .q(tx_q), .sout(tx_sout)
  );

  // rx stops shifting after the last bit, so the decode stays stable
  // through EXEC and CAP.
  assign op        = op_t'(rx_q[FRAME_W-1 -: 2]);
  assign eff       = op_is_next(op) ? ptr + ADDR_W'(1) : rx_q[FRAME_W-3 -: ADDR_W];
  assign d_cap     = op_is_write(op) ? data_q : bus.data_i;
  assign frame_out = {op, addr_q, d_cap};
  assign unused    = ^{rx_sout, tx_q};

  always_ff @(posedge sclk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rx_shift = 1'b0;
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    exec     = 1'b0;
    miso_n   = 1'b0;
    unique case (state)
      IDLE: if (!bus.cs_n) begin
        rx_shift = 1'b1;
        cnt_n    = CNT_W'(1);
        state_n  = RX;
      end
      RX: if (bus.cs_n) begin
        cnt_n   = '0;
        state_n = IDLE;
      end else begin
        rx_shift = 1'b1;
        cnt_n    = cnt + CNT_W'(1);
        if (cnt == CNT_W'(FRAME_W - 1)) state_n = EXEC;
      end
      // Frame is complete: the op commits even if cs_n rises now.
      EXEC: begin
        exec    = 1'b1;
        cnt_n   = '0;
        state_n = bus.cs_n ? IDLE : CAP;
      end
      CAP: if (bus.cs_n) begin
        state_n = IDLE;
      end else begin
        tx_load = 1'b1;
        miso_n  = frame_out[FRAME_W-1];
        state_n = TX;
      end
      TX: if (bus.cs_n) begin
        cnt_n   = '0;
        state_n = IDLE;
      end else begin
        tx_shift = 1'b1;
        cnt_n    = cnt + CNT_W'(1);
        if (cnt == CNT_W'(FRAME_W - 1)) begin
          cnt_n   = '0;
          state_n = HOLD;
        end else begin
          miso_n = tx_sout;
        end
      end
      HOLD: if (bus.cs_n) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      cnt    <= '0;
      ptr    <= '1;  // first *_NEXT after reset lands on address 0
      addr_q <= '0;
      data_q <= '0;
      r_en_q <= 1'b0;
      w_en_q <= 1'b0;
      miso_q <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      miso_q <= miso_n;
      r_en_q <= exec && !op_is_write(op);
      w_en_q <= exec &&  op_is_write(op);
      if (exec) begin
        ptr    <= eff;
        addr_q <= eff;
        if (op_is_write(op)) data_q <= rx_q[DATA_W-1:0];
      end
    end
  end

  assign bus.miso   = miso_q;
  assign bus.r_en   = r_en_q;
  assign bus.w_en   = w_en_q;
  assign bus.addr   = addr_q;
  assign bus.data_o = data_q;

endmodule

// File: tb/tb_spi_sub_gen.sv
// Bench for spi_sub_gen: a default-size instance (10/32) and a small one
// (6/16) share clock, reset and mosi; each has its own cs_n and memory.
// Expected strobes, addresses and echoed frames come from a reference model
// that tracks the pointer and memory contents arithmetically.
module tb_spi_sub_gen;

  logic sclk, rst, cs_a, cs_b, mosi;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [31:0] mem_a [1024];
  logic [15:0] mem_b [64];

  // reference model state, index 0 = default instance, 1 = small instance
  logic [63:0] rmem  [2][1024];
  logic [15:0] rptr  [2];
  logic [15:0] raddr [2];
  logic [63:0] rdout [2];

  spi_sub_gen_if #(.ADDR_W(10), .DATA_W(32)) bus_a ();
  spi_sub_gen_if #(.ADDR_W(6),  .DATA_W(16)) bus_b ();

  spi_sub_gen #(.ADDR_W(10), .DATA_W(32)) dut_a (.sclk(sclk), .rst(rst), .bus(bus_a));
  spi_sub_gen #(.ADDR_W(6),  .DATA_W(16)) dut_b (.sclk(sclk), .rst(rst), .bus(bus_b));

  assign bus_a.cs_n   = cs_a;
  assign bus_a.mosi   = mosi;
  assign bus_a.data_i = mem_a[bus_a.addr];
  assign bus_b.cs_n   = cs_b;
  assign bus_b.mosi   = mosi;
  assign bus_b.data_i = mem_b[bus_b.addr];

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  always @(posedge sclk) begin
    if (bus_a.w_en) mem_a[bus_a.addr] <= bus_a.data_o;
    if (bus_b.w_en) mem_b[bus_b.addr] <= bus_b.data_o;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] o_addr(bit s);
    return s ? 64'(bus_b.addr) : 64'(bus_a.addr);
  endfunction
  function automatic logic [63:0] o_dout(bit s);
    return s ? 64'(bus_b.data_o) : 64'(bus_a.data_o);
  endfunction
  function automatic logic o_ren(bit s);  return s ? bus_b.r_en : bus_a.r_en; endfunction
  function automatic logic o_wen(bit s);  return s ? bus_b.w_en : bus_a.w_en; endfunction
  function automatic logic o_miso(bit s); return s ? bus_b.miso : bus_a.miso; endfunction

  task automatic set_cs(input bit s, input logic v);
    if (s) cs_b = v;
    else   cs_a = v;
  endtask

  function automatic void model_reset();
    rptr[0] = 16'h03FF;
    rptr[1] = 16'h003F;
    for (int s = 0; s < 2; s++) begin
      raddr[s] = 16'h0;
      rdout[s] = 64'h0;
    end
  endfunction

  task automatic do_reset();
    @(negedge sclk);
    rst = 1'b1;
    @(negedge sclk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_r_en",   64'(o_ren(s[0])),  64'd0);
      chk("rst_w_en",   64'(o_wen(s[0])),  64'd0);
      chk("rst_addr",   o_addr(s[0]),      64'd0);
      chk("rst_data_o", o_dout(s[0]),      64'd0);
      chk("rst_miso",   64'(o_miso(s[0])), 64'd0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  // mode 0: full frame, 1: cs_n rises after `cut` request bits,
  // 2: cs_n rises after `cut` response bits, 3: rst pulse right after P_FW
  task automatic xfer(input bit sel, input logic [1:0] op, input logic [15:0] a,
                      input logic [63:0] d, input int mode, input int cut);
    int          aw, dw, fw, strobes, st_cyc, zero_bad, exp_st, last;
    logic [63:0] amask, dmask, frame, rd, resp, exp_got, exp_dout, got, st_addr, st_d;
    logic [15:0] eff;
    logic        st_w;
    aw    = sel ? 6 : 10;
    dw    = sel ? 16 : 32;
    fw    = 2 + aw + dw;
    amask = (64'd1 << aw) - 64'd1;
    dmask = (64'd1 << dw) - 64'd1;
    frame = (64'(op) << (aw + dw)) | ((64'(a) & amask) << dw) | (d & dmask);

    eff      = op[1] ? 16'((64'(rptr[sel]) + 64'd1) & amask) : 16'(64'(a) & amask);
    rd       = op[0] ? (d & dmask) : rmem[sel][eff];
    resp     = (64'(op) << (aw + dw)) | (64'(eff) << dw) | rd;
    exp_dout = op[0] ? (d & dmask) : rdout[sel];
    exp_st   = (mode == 0 || mode == 2) ? 1 : 0;
    if (mode == 0)      exp_got = resp;
    else if (mode == 2) exp_got = resp & ~((64'd1 << (fw - cut)) - 64'd1);
    else                exp_got = 64'd0;

    strobes = 0; st_cyc = -1; st_w = 1'b0; st_addr = 64'd0; st_d = 64'd0;
    got = 64'd0; zero_bad = 0;
    last = 3 * fw + 6;

    @(negedge sclk);
    set_cs(sel, 1'b0);
    mosi = frame[fw-1];
    for (int e = 1; e <= last; e++) begin
      @(negedge sclk);  // outputs after posedge P_e
      if (o_ren(sel) || o_wen(sel)) begin
        strobes++;
        st_cyc  = e;
        st_w    = o_wen(sel);
        st_addr = o_addr(sel);
        st_d    = o_dout(sel);
      end
      if (e >= fw + 2 && e <= 2 * fw + 1) got[2*fw+1-e] = o_miso(sel);
      else if (o_miso(sel)) zero_bad++;
      if (mode == 3 && e == fw + 1) begin
        chk("midrst_addr",   o_addr(sel), 64'd0);
        chk("midrst_data_o", o_dout(sel), 64'd0);
        rst = 1'b0;
        set_cs(sel, 1'b1);
      end
      if (e < fw) mosi = frame[fw-1-e];
      else        mosi = 1'($urandom);
      if (mode == 1 && e == cut)          set_cs(sel, 1'b1);
      if (mode == 2 && e == fw + 1 + cut) set_cs(sel, 1'b1);
      if (mode == 3 && e == fw)           rst = 1'b1;
    end
    set_cs(sel, 1'b1);
    repeat (2) @(negedge sclk);

    if (exp_st == 1) begin
      rptr[sel]  = eff;
      raddr[sel] = eff;
      if (op[0]) begin
        rmem[sel][eff] = d & dmask;
        rdout[sel]     = d & dmask;
      end
    end
    if (mode == 3) model_reset();

    chk("strobe_count", 64'(strobes), 64'(exp_st));
    if (exp_st == 1) begin
      chk("strobe_cycle",  64'(st_cyc), 64'(fw + 1));
      chk("strobe_is_wr",  64'(st_w),   64'(op[0]));
      chk("strobe_addr",   st_addr,     64'(eff));
      chk("strobe_data_o", st_d,        exp_dout);
    end
    chk("response",     got,                64'(exp_got));
    chk("miso_quiet",   64'(zero_bad),      64'd0);
    chk("addr_hold",    o_addr(sel),        64'(raddr[sel]));
    chk("data_o_hold",  o_dout(sel),        rdout[sel]);
  endtask

  initial begin
    bit          s;
    logic [1:0]  op;
    logic [15:0] a;
    logic [63:0] d;
    int          r, mode, cut, fw;
    rst = 1'b1; cs_a = 1'b1; cs_b = 1'b1; mosi = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i]   = 32'h0;
      rmem[0][i] = 64'h0;
      rmem[1][i] = 64'h0;
    end
    for (int i = 0; i < 64; i++) mem_b[i] = 16'h0;
    model_reset();
    do_reset();

    // default-size directed cases
    xfer(0, 2'b01, 16'h3FF, 64'hDEADBEEF, 0, 0);
    xfer(0, 2'b00, 16'h3FF, 64'h0,        0, 0);
    do_reset();
    xfer(0, 2'b11, 16'h155, 64'h11111111, 0, 0);   // lands on 0x000
    xfer(0, 2'b11, 16'h2AA, 64'h22222222, 0, 0);   // lands on 0x001
    xfer(0, 2'b01, 16'h3FF, 64'h5A5A5A5A, 0, 0);
    xfer(0, 2'b10, 16'h123, 64'h0,        0, 0);   // wraps to 0x000
    xfer(0, 2'b01, 16'h010, 64'h01234567, 0, 0);
    xfer(0, 2'b01, 16'h005, 64'hFFFFFFFF, 1, 20);  // aborted after 20 bits
    xfer(0, 2'b10, 16'h0,   64'h0,        0, 0);   // pointer still at 0x010
    xfer(0, 2'b01, 16'h005, 64'hCAFEBABE, 0, 0);
    xfer(0, 2'b01, 16'h0AA, 64'h12345678, 3, 0);   // reset in EXEC
    xfer(0, 2'b10, 16'h0,   64'h0,        0, 0);   // back to 0x000
    xfer(0, 2'b00, 16'h005, 64'h0,        2, 13);  // deselect mid-response

    // small instance
    xfer(1, 2'b01, 16'h3F, 64'hBEEF, 0, 0);
    xfer(1, 2'b00, 16'h3F, 64'h0,    0, 0);

    for (int i = 0; i < 40; i++) begin
      s  = ($urandom_range(0, 3) == 0);
      op = 2'($urandom);
      r  = $urandom_range(0, 2);
      a  = (r == 0) ? 16'($urandom_range(0, 3)) : (r == 1) ? 16'hFFFF : 16'($urandom);
      d  = {$urandom, $urandom};
      fw = s ? 24 : 44;
      r  = $urandom_range(0, 9);
      mode = (r < 7) ? 0 : (r == 7) ? 1 : (r == 8) ? 2 : 3;
      cut  = $urandom_range(1, fw - 1);
      xfer(s, op, a, d, mode, cut);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
